// File: rtl/q_pulse_emulator.sv
// Clocked resonant-system emulator: converts a latched current reference into
// a delivered charge and serialises it as fixed-width pulses for the Q-measurement path.
//
// state | meaning
// IDLE  | waiting for a rising start edge with enable high
// HIGH  | pulse phase, q_serialized high for PULSE_DURATION cycles
// LOW   | gap phase, q_serialized low for GAP_DURATION cycles
// DONE  | one-cycle completion strobe, then back to IDLE
module q_pulse_emulator #(
  parameter int BUS_WIDTH          = 10,
  parameter int PULSE_DURATION     = 3,
  parameter int GAP_DURATION       = 2,
  parameter int Q_PER_PULSE        = 1,
  parameter int GAIN_NUM           = 1,
  parameter int GAIN_SHIFT         = 0,
  parameter int I_REF_INSTB        = 900,
  parameter int EXTRA_PULSES_INSTB = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] i_ref,
  output logic                 q_serialized,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] pulses_emitted
);

  localparam int CW      = BUS_WIDTH + 8;
  localparam int RW      = BUS_WIDTH + 9;
  localparam int DUR_MAX = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
  localparam int TW      = $clog2(DUR_MAX + 1);

  localparam logic [7:0]           GAIN       = 8'(GAIN_NUM);
  localparam logic [RW-1:0]        Q_STEP     = RW'(Q_PER_PULSE);
  localparam logic [RW-1:0]        EXTRA_Q    = RW'(EXTRA_PULSES_INSTB * Q_PER_PULSE);
  localparam logic [TW-1:0]        PULSE_LOAD = TW'(PULSE_DURATION - 1);
  localparam logic [TW-1:0]        GAP_LOAD   = TW'(GAP_DURATION - 1);
  localparam logic [BUS_WIDTH-1:0] PE_MAX     = '1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t          state;
  logic            start_d;
  logic [RW-1:0]   remaining;
  logic [TW-1:0]   dur_cnt;

  logic [CW-1:0]   product;
  logic [CW-1:0]   charge;
  logic            instb;
  logic [RW-1:0]   remaining_init;

  // Charge is computed every cycle but only captured on a trigger, so later
  // i_ref changes never disturb a run in progress.
  assign product        = CW'(i_ref) * CW'(GAIN);
  assign charge         = product >> GAIN_SHIFT;
  assign instb          = (32'(i_ref) >= I_REF_INSTB);
  assign remaining_init = RW'(charge) + (instb ? EXTRA_Q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      start_d        <= 1'b0;
      remaining      <= '0;
      dur_cnt        <= '0;
      q_serialized   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pulses_emitted <= '0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      if (!enable) begin
        // Abort: no completion strobe, pulse count is kept for inspection.
        state        <= S_IDLE;
        q_serialized <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !start_d) begin
              remaining      <= remaining_init;
              pulses_emitted <= '0;
              if (remaining_init >= Q_STEP) begin
                state        <= S_HIGH;
                dur_cnt      <= PULSE_LOAD;
                q_serialized <= 1'b1;
                busy         <= 1'b1;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (dur_cnt == '0) begin
              state        <= S_LOW;
              dur_cnt      <= GAP_LOAD;
              q_serialized <= 1'b0;
              remaining    <= remaining - Q_STEP;
              if (pulses_emitted != PE_MAX)
                pulses_emitted <= pulses_emitted + 1'b1;
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
          S_LOW: begin
            if (dur_cnt == '0) begin
              // Residue below one pulse's worth of charge is dropped here.
              if (remaining >= Q_STEP) begin
                state        <= S_HIGH;
                dur_cnt      <= PULSE_LOAD;
                q_serialized <= 1'b1;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_q_pulse_emulator.sv
// Directed bench for q_pulse_emulator: four parameterisations, a per-cycle reference
// model fed from a scoreboard queue of expected runs.
module tb_q_pulse_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable [4];
  logic       start  [4];
  logic [9:0] i_ref  [4];
  logic       q      [4];
  logic       busy   [4];
  logic       done   [4];
  logic [9:0] pe     [4];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int inst;
    int k;
    int n;
    int abort_at;
  } run_t;

  run_t sb[$];
  run_t cur [4];
  bit   act [4];
  int   exp_pe [4];

  localparam int NO_ABORT = 1 << 30;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: defaults, 1: gain/residue, 2: instability, 3: saturation (no injection)
  q_pulse_emulator u_def (
    .clk(clk), .rst(rst), .enable(enable[0]), .start(start[0]), .i_ref(i_ref[0]),
    .q_serialized(q[0]), .busy(busy[0]), .done(done[0]), .pulses_emitted(pe[0]));

  q_pulse_emulator #(.GAIN_NUM(3), .GAIN_SHIFT(1), .Q_PER_PULSE(2)) u_gain (
    .clk(clk), .rst(rst), .enable(enable[1]), .start(start[1]), .i_ref(i_ref[1]),
    .q_serialized(q[1]), .busy(busy[1]), .done(done[1]), .pulses_emitted(pe[1]));

  q_pulse_emulator #(.I_REF_INSTB(8), .EXTRA_PULSES_INSTB(4)) u_instb (
    .clk(clk), .rst(rst), .enable(enable[2]), .start(start[2]), .i_ref(i_ref[2]),
    .q_serialized(q[2]), .busy(busy[2]), .done(done[2]), .pulses_emitted(pe[2]));

  q_pulse_emulator #(.GAIN_NUM(2), .EXTRA_PULSES_INSTB(0)) u_sat (
    .clk(clk), .rst(rst), .enable(enable[3]), .start(start[3]), .i_ref(i_ref[3]),
    .q_serialized(q[3]), .busy(busy[3]), .done(done[3]), .pulses_emitted(pe[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Reference model: pulse n high for d in [5n, 5n+3), done at d = 5N.
  always @(negedge clk) begin
    int d, np;
    logic eq, eb, ed;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        act[i]    = 1'b0;
        exp_pe[i] = 0;
      end
    end else begin
      if (sb.size() > 0 && sb[0].k == cyc) begin
        cur[sb[0].inst] = sb[0];
        act[sb[0].inst] = 1'b1;
        void'(sb.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        eq = 1'b0;
        eb = 1'b0;
        ed = 1'b0;
        if (act[i] && cyc >= cur[i].abort_at) act[i] = 1'b0;
        if (act[i]) begin
          d  = cyc - cur[i].k;
          eq = (d < cur[i].n * 5) && ((d % 5) < 3);
          eb = (d < cur[i].n * 5);
          ed = (d == cur[i].n * 5);
          np = (d >= 3) ? ((d - 3) / 5 + 1) : 0;
          if (np > cur[i].n) np = cur[i].n;
          exp_pe[i] = (np > 1023) ? 1023 : np;
          if (ed) act[i] = 1'b0;
        end
        check($sformatf("q%0d", i),    32'(q[i]),    32'(eq));
        check($sformatf("busy%0d", i), 32'(busy[i]), 32'(eb));
        check($sformatf("done%0d", i), 32'(done[i]), 32'(ed));
        check($sformatf("pe%0d", i),   32'(pe[i]),   exp_pe[i]);
      end
    end
  end

  task automatic push_run(input int inst, input int n, input int abort_at, output int k);
    run_t r;
    k          = cyc + 1;
    r.inst     = inst;
    r.k        = k;
    r.n        = n;
    r.abort_at = abort_at;
    sb.push_back(r);
  endtask

  task automatic wait_done(input int inst, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = done[inst];
    end
    check($sformatf("done_seen%0d", inst), 32'(seen), 32'd1);
  endtask

  task automatic run(input int inst, input int iref, input int n, input int budget);
    int k;
    @(negedge clk);
    i_ref[inst] = 10'(iref);
    start[inst] = 1'b1;
    push_run(inst, n, NO_ABORT, k);
    wait_done(inst, budget);
    repeat (6) @(negedge clk);
    start[inst] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      enable[i] = 1'b1;
      start[i]  = 1'b0;
      i_ref[i]  = '0;
    end
    start[0] = 1'b1;
    i_ref[0] = 10'd5;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_q%0d", i),    32'(q[i]),    32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_pe%0d", i),   32'(pe[i]),   32'd0);
    end

    // start already high at the first edge after reset is a trigger
    @(negedge clk);
    rst = 1'b0;
    push_run(0, 5, NO_ABORT, k);
    wait_done(0, 60);
    repeat (10) @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 0, 0, 10);
    run(1, 7, 5, 60);
    run(1, 6, 4, 60);
    run(2, 10, 14, 100);
    run(2, 7, 7, 60);

    // abort during the third pulse's high phase (d = 10..12)
    @(negedge clk);
    i_ref[0] = 10'd5;
    start[0] = 1'b1;
    push_run(0, 5, cyc + 12, k);
    repeat (11) @(negedge clk);
    enable[0] = 1'b0;
    @(negedge clk);
    check("abort_q",    32'(q[0]),    32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_pe",   32'(pe[0]),   32'd2);
    repeat (30) @(negedge clk);
    check("abort_pe_hold", 32'(pe[0]), 32'd2);
    enable[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of the first gap
    @(negedge clk);
    start[0] = 1'b1;
    push_run(0, 5, NO_ABORT, k);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_q",    32'(q[0]),    32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_done", 32'(done[0]), 32'd0);
    check("arst_pe",   32'(pe[0]),   32'd0);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run(3, 1023, 2046, 10300);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
